cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run controller for the single-cycle CPU. It sequences execution by gating a per-cycle advance enable into the PC and register-file write path, and supports free run, single step, an external stop, one PC breakpoint and a run-length cycle limit. It sits between the testbench or debug host and `CPU`, and keeps a total executed-cycle counter so that benches stop on a controller halt instead of counting clock edges.

## Interface
Parameters:
- `PC_W`, 32, width of the PC and the breakpoint address.
- `CNT_W`, 32, width of the total cycle counter.
- `LIM_W`, 16, width of the run-limit value and the per-run counter.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  begin or resume free run; level, sampled each cycle.
- `step_i`  in  1  execute exactly one instruction; sampled each cycle.
- `stop_i`  in  1  request halt.
- `clr_i`  in  1  synchronous clear of `cycle_cnt_o`.
- `run_limit_i`  in  LIM_W  maximum instructions per run; 0 means unlimited.
- `bp_en_i`  in  1  breakpoint enable.
- `bp_addr_i`  in  PC_W  breakpoint PC.
- `pc_i`  in  PC_W  current CPU PC (`pc_o` of the PC module).
- `cpu_en_o`  out  1  advance enable; the CPU updates PC and writes registers only when high.
- `busy_o`  out  1  high in RUN or STEP.
- `halted_o`  out  1  high in HALT.
- `halt_cause_o`  out  2  0 none, 1 stop, 2 breakpoint, 3 limit.
- `cycle_cnt_o`  out  CNT_W  total cycles with `cpu_en_o` high; saturates.

## Operation
- States: IDLE, RUN, STEP, HALT. Reset puts the block in IDLE with every output 0, `run_cnt`=0 and `bp_skip`=0.
- `bp_hit` = `bp_en_i` & (`pc_i`==`bp_addr_i`) & !`bp_skip`.
- `lim_hit` = (`run_limit_i`!=0) & (`run_cnt`==`run_limit_i`).
- `cpu_en_o` is combinational:
  - in RUN: (!`bp_hit` & !`lim_hit` & !`stop_i`);
  - in STEP: 1;
  - in all other states: 0.
- IDLE or HALT:
  - `start_i` goes to RUN, clears `run_cnt` and `halt_cause_o`, and sets `bp_skip`=1 when leaving HALT with cause 2.
  - Otherwise `step_i` goes to STEP. If both are high, start wins.
- RUN, evaluated in priority order:
  - `stop_i` goes to HALT with cause 1.
  - `bp_hit` goes to HALT with cause 2. The breakpoint instruction is not executed.
  - `lim_hit` goes to HALT with cause 3.
  - Otherwise stay in RUN.
- STEP goes to HALT after one cycle, with cause 0, regardless of `bp_hit` or `lim_hit`. Stepping over a breakpoint is legal.
- `bp_skip` clears on the first cycle in RUN in which `cpu_en_o`=1.
- `run_cnt` increments when `cpu_en_o`=1 and saturates at all-ones.
- `cycle_cnt_o` increments when `cpu_en_o`=1 and saturates at 2^CNT_W−1.
- `clr_i` has priority over the increment: `cycle_cnt_o` becomes 0 that cycle.
- `start_i` and `step_i` are ignored while in RUN or STEP.

## Timing
- State, counters, `halt_cause_o`, `busy_o` and `halted_o` are registered and update one edge after the triggering input is sampled.
- `cpu_en_o` reacts in the same cycle to `pc_i`, `stop_i` and `lim_hit`. This zero-latency gating is what keeps the breakpoint, stop and limit instruction from executing.
- Run sequence: `start_i` sampled at edge N; RUN from N; `cpu_en_o` first high in cycle N..N+1.
- Limit L: exactly L cycles with `cpu_en_o`=1, then HALT one edge after `lim_hit`.
- Asynchronous reset mid-run forces IDLE and `cpu_en_o`=0 immediately, without waiting for a clock edge.

## Structure
- Package `cpu_run_pkg` holds:
  - state enum IDLE=2'd0, RUN=2'd1, STEP=2'd2, HALT=2'd3;
  - halt-cause constants CAUSE_NONE, CAUSE_STOP, CAUSE_BP, CAUSE_LIMIT.
- One sub-module, `sat_counter` (parameter W; ports `inc`, `clr`, `q`), instantiated for both `run_cnt` and `cycle_cnt`.
- The FSM and breakpoint logic live in `cpu_run_ctrl`.

## Test plan
- Reset, then `start_i` pulse with `run_limit_i`=30 and no breakpoint. Required: exactly 30 cycles of `cpu_en_o`=1, then `halted_o`=1, `halt_cause_o`=3, `cycle_cnt_o`=30.
- `bp_addr_i`=0x10, `pc_i` advancing by 4 per enabled cycle. Required: halt with `pc_i`=0x10, `cpu_en_o`=0 in that cycle, cause 2, `cycle_cnt_o`=4.
- From that breakpoint halt, `start_i` again. Required: PC leaves 0x10 without re-triggering; the next hit occurs only if the PC returns to 0x10.
- Three `step_i` pulses from IDLE, each separated by at least one idle cycle. Required: three single-cycle `cpu_en_o` pulses, `cycle_cnt_o`=3, `halt_cause_o`=0.
- `stop_i` asserted during RUN with `clr_i` asserted in the same cycle. Required: `cpu_en_o`=0 in that cycle, HALT with cause 1, `cycle_cnt_o`=0 on the next edge.
- `rst_i` low mid-run between clock edges. Required: `cpu_en_o` drops immediately; all outputs are 0 and the state is IDLE until `start_i`.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the CPU run controller: FSM state encoding and halt-cause codes.
package cpu_run_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } state_t;

  typedef logic [1:0] cause_t;

  localparam cause_t CAUSE_NONE  = 2'd0;
  localparam cause_t CAUSE_STOP  = 2'd1;
  localparam cause_t CAUSE_BP    = 2'd2;
  localparam cause_t CAUSE_LIMIT = 2'd3;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Control/status bundle between the debug host (master) and the run controller (slave).
interface cpu_run_ctrl_if
  import cpu_run_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32,
  parameter int LIM_W = 16
);
  logic             start_i;
  logic             step_i;
  logic             stop_i;
  logic             clr_i;
  logic [LIM_W-1:0] run_limit_i;
  logic             bp_en_i;
  logic [PC_W-1:0]  bp_addr_i;
  logic [PC_W-1:0]  pc_i;
  logic             cpu_en_o;
  logic             busy_o;
  logic             halted_o;
  cause_t           halt_cause_o;
  logic [CNT_W-1:0] cycle_cnt_o;

  modport master (
    output start_i, step_i, stop_i, clr_i, run_limit_i, bp_en_i, bp_addr_i, pc_i,
    input  cpu_en_o, busy_o, halted_o, halt_cause_o, cycle_cnt_o
  );

  modport slave (
    input  start_i, step_i, stop_i, clr_i, run_limit_i, bp_en_i, bp_addr_i, pc_i,
    output cpu_en_o, busy_o, halted_o, halt_cause_o, cycle_cnt_o
  );
endinterface

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  // NOTE: sequential state is written only with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: gates the CPU advance enable for free run, single step, stop,
// one PC breakpoint and a per-run instruction limit; counts executed cycles.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32,
  parameter int LIM_W = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  cpu_run_ctrl_if.slave  bus
);

  state_t           state, state_nx;
  cause_t           cause, cause_nx;
  logic             bp_skip, bp_skip_nx;
  logic             run_clr;
  logic             cpu_en;
  logic             pc_match;
  logic             bp_hit;
  logic             lim_hit;
  logic [LIM_W-1:0] run_cnt;

  assign pc_match = (PC_W'(bus.pc_i) == PC_W'(bus.bp_addr_i));
  // bp_skip lets a resumed run execute the instruction it stopped on.
  assign bp_hit   = bus.bp_en_i & pc_match & ~bp_skip;
  assign lim_hit  = (bus.run_limit_i != '0) & (run_cnt == bus.run_limit_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      cause   <= CAUSE_NONE;
      bp_skip <= 1'b0;
    end else begin
      state   <= state_nx;
      cause   <= cause_nx;
      bp_skip <= bp_skip_nx;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_nx   = state;
    cause_nx   = cause;
    bp_skip_nx = bp_skip;
    run_clr    = 1'b0;
    cpu_en     = 1'b0;
    unique case (state)
      IDLE, HALT: begin
        if (bus.start_i) begin
          state_nx   = RUN;
          cause_nx   = CAUSE_NONE;
          run_clr    = 1'b1;
          bp_skip_nx = (state == HALT) && (cause == CAUSE_BP);
        end else if (bus.step_i) begin
          state_nx = STEP;
        end
      end
      RUN: begin
        cpu_en = ~bp_hit & ~lim_hit & ~bus.stop_i;
        if (cpu_en) bp_skip_nx = 1'b0;
        if (bus.stop_i) begin
          state_nx = HALT;
          cause_nx = CAUSE_STOP;
        end else if (bp_hit) begin
          state_nx = HALT;
          cause_nx = CAUSE_BP;
        end else if (lim_hit) begin
          state_nx = HALT;
          cause_nx = CAUSE_LIMIT;
        end
      end
      STEP: begin
        cpu_en   = 1'b1;
        state_nx = HALT;
        cause_nx = CAUSE_NONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  sat_counter #(.W(LIM_W)) u_run_cnt (
    .clk   (clk_i),
    .rst_n (rst_i),
    .inc   (cpu_en),
    .clr   (run_clr),
    .q     (run_cnt)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk_i),
    .rst_n (rst_i),
    .inc   (cpu_en),
    .clr   (bus.clr_i),
    .q     (bus.cycle_cnt_o)
  );

  assign bus.cpu_en_o     = cpu_en;
  assign bus.busy_o       = (state == RUN) || (state == STEP);
  assign bus.halted_o     = (state == HALT);
  assign bus.halt_cause_o = cause;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: per-cycle vector table plus multi-cycle sequences.
module tb_cpu_run_ctrl;
  import cpu_run_pkg::*;

  localparam int PC_W  = 32;
  localparam int CNT_W = 32;
  localparam int LIM_W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W), .LIM_W(LIM_W)) bus ();

  cpu_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .LIM_W(LIM_W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        start, step, stop, clr;
    logic [15:0] lim;
    logic        bp_en;
    logic [31:0] bp_addr, pc;
    logic        en;
    logic        busy, halted;
    logic [1:0]  cause;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(
    input logic start, step, stop, clr, input logic [15:0] lim, input logic bp_en,
    input logic [31:0] bp_addr, pc, input logic en, busy, halted,
    input logic [1:0] cause, input logic [31:0] cnt);
    vec_t v;
    v.start = start; v.step = step; v.stop = stop; v.clr = clr; v.lim = lim;
    v.bp_en = bp_en; v.bp_addr = bp_addr; v.pc = pc; v.en = en; v.busy = busy;
    v.halted = halted; v.cause = cause; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return (pc == 32'h1C) ? 32'h10 : pc + 32'd4;
  endfunction

  task automatic drive_idle();
    bus.start_i = 0; bus.step_i = 0; bus.stop_i = 0; bus.clr_i = 0;
    bus.run_limit_i = '0; bus.bp_en_i = 0; bus.bp_addr_i = '0; bus.pc_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pulses start, then runs until halted; pc advances by pc_next on enabled cycles.
  task automatic run_until_halt(input int budget, output int en_cnt, output logic first_en,
                                output logic last_en, output logic done);
    logic en;
    en_cnt = 0; first_en = 0; last_en = 1; done = 0;
    @(negedge clk); bus.start_i = 1;
    @(negedge clk); bus.start_i = 0;
    for (int c = 0; c < budget; c++) begin
      #1;
      if (bus.halted_o) begin
        done = 1;
        break;
      end
      en = bus.cpu_en_o;
      if (c == 0) first_en = en;
      last_en = en;
      if (en) en_cnt++;
      @(posedge clk); #1;
      if (en) bus.pc_i = pc_next(bus.pc_i);
      @(negedge clk);
    end
  endtask

  int   en_cnt;
  logic first_en, last_en, done;

  initial begin
    drive_idle();

    //                start step stop clr lim  bp bp_addr  pc       en busy hlt cause cnt
    vecs[0]  = mk(0, 0, 0, 0, 16'd0, 0, 32'h0,  32'h0,  0, 0, 0, 2'd0, 32'd0);
    vecs[1]  = mk(0, 1, 0, 0, 16'd0, 0, 32'h0,  32'h0,  0, 1, 0, 2'd0, 32'd0);
    vecs[2]  = mk(0, 0, 0, 0, 16'd0, 0, 32'h0,  32'h0,  1, 0, 1, 2'd0, 32'd1);
    vecs[3]  = mk(1, 1, 0, 0, 16'd2, 0, 32'h0,  32'h0,  0, 1, 0, 2'd0, 32'd1);
    vecs[4]  = mk(0, 0, 0, 0, 16'd2, 0, 32'h0,  32'h0,  1, 1, 0, 2'd0, 32'd2);
    vecs[5]  = mk(1, 0, 0, 0, 16'd2, 0, 32'h0,  32'h0,  1, 1, 0, 2'd0, 32'd3);
    vecs[6]  = mk(0, 0, 0, 0, 16'd2, 0, 32'h0,  32'h0,  0, 0, 1, 2'd3, 32'd3);
    vecs[7]  = mk(0, 0, 0, 1, 16'd2, 0, 32'h0,  32'h0,  0, 0, 1, 2'd3, 32'd0);
    vecs[8]  = mk(1, 0, 0, 0, 16'd0, 1, 32'h40, 32'h40, 0, 1, 0, 2'd0, 32'd0);
    vecs[9]  = mk(0, 0, 0, 0, 16'd0, 1, 32'h40, 32'h40, 0, 0, 1, 2'd2, 32'd0);
    vecs[10] = mk(1, 0, 0, 0, 16'd0, 1, 32'h40, 32'h40, 0, 1, 0, 2'd0, 32'd0);
    vecs[11] = mk(0, 0, 0, 0, 16'd0, 1, 32'h40, 32'h40, 1, 1, 0, 2'd0, 32'd1);
    vecs[12] = mk(0, 0, 0, 0, 16'd0, 1, 32'h40, 32'h40, 0, 0, 1, 2'd2, 32'd1);
    vecs[13] = mk(0, 1, 0, 0, 16'd0, 1, 32'h40, 32'h40, 0, 1, 0, 2'd2, 32'd1);
    vecs[14] = mk(0, 0, 0, 0, 16'd0, 1, 32'h40, 32'h40, 1, 0, 1, 2'd0, 32'd2);
    vecs[15] = mk(1, 0, 0, 0, 16'd0, 0, 32'h0,  32'h0,  0, 1, 0, 2'd0, 32'd2);
    vecs[16] = mk(0, 0, 1, 0, 16'd0, 0, 32'h0,  32'h0,  0, 0, 1, 2'd1, 32'd2);

    // Reset state
    do_reset();
    #1;
    check("rst_en",     bus.cpu_en_o,     1'b0);
    check("rst_busy",   bus.busy_o,       1'b0);
    check("rst_halted", bus.halted_o,     1'b0);
    check("rst_cause",  bus.halt_cause_o, 2'd0);
    check("rst_cnt",    bus.cycle_cnt_o,  32'd0);

    // Per-cycle vector table
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus.start_i = vecs[i].start; bus.step_i = vecs[i].step;
      bus.stop_i  = vecs[i].stop;  bus.clr_i  = vecs[i].clr;
      bus.run_limit_i = vecs[i].lim; bus.bp_en_i = vecs[i].bp_en;
      bus.bp_addr_i = vecs[i].bp_addr; bus.pc_i = vecs[i].pc;
      #1;
      check($sformatf("vec%0d_en", i), bus.cpu_en_o, vecs[i].en);
      @(posedge clk); #1;
      check($sformatf("vec%0d_busy", i),   bus.busy_o,       vecs[i].busy);
      check($sformatf("vec%0d_halted", i), bus.halted_o,     vecs[i].halted);
      check($sformatf("vec%0d_cause", i),  bus.halt_cause_o, vecs[i].cause);
      check($sformatf("vec%0d_cnt", i),    bus.cycle_cnt_o,  vecs[i].cnt);
    end

    // Run limit of 30
    do_reset();
    bus.run_limit_i = 16'd30;
    run_until_halt(100, en_cnt, first_en, last_en, done);
    check("lim_done",   done,             1'b1);
    check("lim_en_cnt", en_cnt,           30);
    check("lim_cause",  bus.halt_cause_o, 2'd3);
    check("lim_cnt",    bus.cycle_cnt_o,  32'd30);

    // Breakpoint at 0x10 from pc 0
    do_reset();
    bus.bp_en_i = 1; bus.bp_addr_i = 32'h10; bus.pc_i = 32'h0;
    run_until_halt(100, en_cnt, first_en, last_en, done);
    check("bp_done",    done,             1'b1);
    check("bp_en_cnt",  en_cnt,           4);
    check("bp_last_en", last_en,          1'b0);
    check("bp_pc",      bus.pc_i,         32'h10);
    check("bp_cause",   bus.halt_cause_o, 2'd2);
    check("bp_cnt",     bus.cycle_cnt_o,  32'd4);

    // Resume from the breakpoint: skip once, re-hit after looping back to 0x10
    run_until_halt(100, en_cnt, first_en, last_en, done);
    check("bp2_done",     done,             1'b1);
    check("bp2_first_en", first_en,         1'b1);
    check("bp2_en_cnt",   en_cnt,           4);
    check("bp2_pc",       bus.pc_i,         32'h10);
    check("bp2_cause",    bus.halt_cause_o, 2'd2);
    check("bp2_cnt",      bus.cycle_cnt_o,  32'd8);

    // Three single steps from IDLE
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); bus.step_i = 1; #1;
      check($sformatf("step%0d_pre_en", k), bus.cpu_en_o, 1'b0);
      @(negedge clk); bus.step_i = 0; #1;
      check($sformatf("step%0d_en", k), bus.cpu_en_o, 1'b1);
      @(negedge clk); #1;
      check($sformatf("step%0d_post_en", k), bus.cpu_en_o, 1'b0);
      check($sformatf("step%0d_halted", k),  bus.halted_o, 1'b1);
    end
    check("step_cnt",   bus.cycle_cnt_o,  32'd3);
    check("step_cause", bus.halt_cause_o, 2'd0);

    // Stop with simultaneous counter clear
    do_reset();
    @(negedge clk); bus.start_i = 1;
    @(negedge clk); bus.start_i = 0;
    repeat (4) @(negedge clk);
    #1;
    check("stop_pre_cnt", bus.cycle_cnt_o, 32'd4);
    bus.stop_i = 1; bus.clr_i = 1;
    #1;
    check("stop_en", bus.cpu_en_o, 1'b0);
    @(posedge clk); #1;
    check("stop_halted", bus.halted_o,     1'b1);
    check("stop_cause",  bus.halt_cause_o, 2'd1);
    check("stop_cnt",    bus.cycle_cnt_o,  32'd0);
    @(negedge clk); bus.stop_i = 0; bus.clr_i = 0;

    // Asynchronous reset mid-run
    do_reset();
    @(negedge clk); bus.start_i = 1;
    @(negedge clk); bus.start_i = 0;
    repeat (3) @(negedge clk);
    #1;
    check("arst_pre_en", bus.cpu_en_o, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_en",     bus.cpu_en_o,     1'b0);
    check("arst_busy",   bus.busy_o,       1'b0);
    check("arst_halted", bus.halted_o,     1'b0);
    check("arst_cause",  bus.halt_cause_o, 2'd0);
    check("arst_cnt",    bus.cycle_cnt_o,  32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      check("arst_idle_busy", bus.busy_o,   1'b0);
      check("arst_idle_en",   bus.cpu_en_o, 1'b0);
    end
    @(negedge clk); bus.start_i = 1;
    @(negedge clk); bus.start_i = 0; #1;
    check("arst_restart_busy", bus.busy_o, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
